srt4_host: RTL and testbench

Host-side initiator for the `srt4` divider's byte-serial bus. It accepts a parallel dividend/divisor request over a valid/ready handshake and drives `beginSignal`/`inbus` to the divider. It then captures quotient and remainder from `outbus` after `endSignal`, and returns them over a second valid/ready handshake. It sits between a bus-side requester and one `srt4` instance and is the only driver of that instance's inputs.

---
 rtl/srt4_host.sv | 136 +++++++++++++
 tb/tb_srt4_host.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/srt4_host.sv
// srt4_host: host-side initiator for the byte-serial srt4 divider.
// Takes a dividend/divisor request, sends it to the divider over
// beginSignal/inbus, and collects the quotient and remainder from outbus
// after endSignal. The result is returned over a response handshake.
// Both handshakes follow the same rule: a transfer happens on a rising edge
// where valid and ready are both high. Valid is held until it is taken.
// Ready never depends on the other side's valid.
module srt4_host #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       err_dbz,
  output logic       err_tmo,
  output logic       div_begin,
  output logic [7:0] div_inbus,
  input  logic [7:0] div_outbus,
  input  logic       div_end,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_DVD = 3'd1,
    SEND_DVS = 3'd2,
    WAIT_END = 3'd3,
    GET_REM  = 3'd4,
    RESP     = 3'd5
  } state_t;

  // The counter only has to reach TIMEOUT-1, so one spare bit is enough.
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t        state;
  state_t        state_next;
  logic [7:0]    dvd_q;
  logic [7:0]    dvs_q;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT - 1));
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. div_end is only examined in WAIT_END, and there it
  // takes priority over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (req_valid) state_next = (divisor == 8'd0) ? RESP : SEND_DVD;
      SEND_DVD: state_next = SEND_DVS;
      SEND_DVS: state_next = WAIT_END;
      WAIT_END: begin
        if (div_end)      state_next = GET_REM;
        else if (tmo_hit) state_next = RESP;
      end
      GET_REM:  state_next = RESP;
      RESP:     if (rsp_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are decoded from state and latched operands only.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    div_begin = (state == SEND_DVD);
    case (state)
      SEND_DVD: div_inbus = dvd_q;
      SEND_DVS: div_inbus = dvs_q;
      WAIT_END: div_inbus = dvs_q;
      default:  div_inbus = 8'd0;
    endcase
  end

  // Datapath: operand latches, result capture, error flags, timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= 8'd0;
      dvs_q     <= 8'd0;
      quotient  <= 8'd0;
      remainder <= 8'd0;
      err_dbz   <= 1'b0;
      err_tmo   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            // A zero divisor never reaches the divider.
            if (divisor == 8'd0) begin
              quotient  <= 8'hFF;
              remainder <= dividend;
              err_dbz   <= 1'b1;
            end
          end
        end
        SEND_DVS: tmo_cnt <= '0;
        WAIT_END: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (div_end) begin
            quotient <= div_outbus;
          end else if (tmo_hit) begin
            err_tmo   <= 1'b1;
            quotient  <= 8'd0;
            remainder <= 8'd0;
          end
        end
        GET_REM:  remainder <= div_outbus;
        RESP: begin
          if (rsp_ready) begin
            err_dbz <= 1'b0;
            err_tmo <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srt4_host.sv
// Testbench for srt4_host with a behavioral byte-serial divider model.
// Cycle numbering: latency counts rising edges from the edge before the
// accept edge, so a divide-by-zero response has latency 1. A normal divide
// whose end pulse arrives D WAIT_END cycles in has latency D+4.
module tb_srt4_host;

  localparam int TMO = 16;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       err_dbz;
  logic       err_tmo;
  logic       div_begin;
  logic [7:0] div_inbus;
  logic [7:0] div_outbus;
  logic       div_end;
  logic [2:0] dbg_state;

  srt4_host #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .err_dbz    (err_dbz),
    .err_tmo    (err_tmo),
    .div_begin  (div_begin),
    .div_inbus  (div_inbus),
    .div_outbus (div_outbus),
    .div_end    (div_end),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- divider model ----------------
  // 0 = never raises end. Otherwise end rises in the m_delay-th WAIT_END cycle.
  int         m_delay = 8;
  bit         m_spur  = 0;
  int         m_ph    = 0;
  int         m_t     = 0;
  int         begins  = 0;
  logic [7:0] m_a = 8'd0;
  logic [7:0] m_b = 8'd0;

  // The divider answers on the falling edge, so the DUT samples stable values.
  always @(negedge clk) begin
    div_end    = 1'b0;
    div_outbus = 8'd0;
    if (div_begin) begins++;
    if (rst || req_ready) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        0: if (div_begin) begin
             m_a  = div_inbus;
             m_ph = 1;
             if (m_spur) begin
               div_end    = 1'b1;
               div_outbus = 8'hAA;
             end
           end
        1: begin
             m_b  = div_inbus;
             m_t  = 0;
             m_ph = 2;
           end
        2: begin
             m_t++;
             if (m_delay != 0 && m_t == m_delay) begin
               div_end    = 1'b1;
               div_outbus = (m_b == 8'd0) ? 8'hFF : m_a / m_b;
               m_ph       = 3;
             end
           end
        3: begin
             div_outbus = (m_b == 8'd0) ? 8'h00 : m_a % m_b;
             m_ph       = 0;
           end
        default: m_ph = 0;
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         d;
    bit         spur;
    int         hold;
    logic [7:0] q;
    logic [7:0] r;
    bit         dbz;
    bit         tmo;
    int         lat;
    int         nbeg;
  } vec_t;

  vec_t tbl[9];
  int   acc_cyc;

  // Present a request and wait for it to be accepted. The expected result
  // goes on the scoreboard at that point.
  task automatic send_req(input vec_t v);
    int n;
    m_delay   = v.d;
    m_spur    = v.spur;
    begins    = 0;
    req_valid = 1'b1;
    dividend  = v.a;
    divisor   = v.b;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", {31'd0, req_ready}, 32'd1);
    acc_cyc = cyc;
    exp_q.push_back({v.q, v.r, v.dbz, v.tmo});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic sb_pop_compare(input string name);
    logic [17:0] e;
    check({name, "_sb_depth"}, exp_q.size(), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, "_result"}, {14'd0, quotient, remainder, err_dbz, err_tmo}, {14'd0, e});
    end
  endtask

  task automatic wait_rsp(input vec_t v, input string name);
    int n;
    bit stable;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rsp_wait"}, {31'd0, rsp_valid}, 32'd1);
    check({name, "_latency"}, cyc - acc_cyc, v.lat);
    if (v.nbeg != 0)
      check({name, "_inbus"}, {16'd0, m_a, m_b}, {16'd0, v.a, v.b});
    stable = 1;
    for (int i = 0; i < v.hold; i++) begin
      if (!(rsp_valid && !req_ready &&
            {quotient, remainder, err_dbz, err_tmo} == {v.q, v.r, v.dbz, v.tmo}))
        stable = 0;
      @(negedge clk);
    end
    if (v.hold > 0) check({name, "_hold_stable"}, {31'd0, stable}, 32'd1);
    rsp_ready = 1'b1;
    sb_pop_compare(name);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_back_idle"}, {28'd0, req_ready, rsp_valid, err_dbz, err_tmo}, 32'b1000);
    check({name, "_begins"}, begins, v.nbeg);
  endtask

  localparam logic [28:0] RESET_OUTS = {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    dividend = 8'd0; divisor = 8'd0;

    //            a       b      d  sp ho  q       r       dbz tmo lat nbeg
    tbl[0] = '{8'd211, 8'd6,   8, 0, 0,  8'd35,  8'd1,   0,  0,  12, 1};
    tbl[1] = '{8'd100, 8'd0,   8, 0, 0,  8'd255, 8'd100, 1,  0,  1,  0};
    tbl[2] = '{8'd77,  8'd9,   0, 0, 0,  8'd0,   8'd0,   0,  1,  19, 1};
    tbl[3] = '{8'd200, 8'd7,   3, 0, 0,  8'd28,  8'd4,   0,  0,  7,  1};
    tbl[4] = '{8'd9,   8'd10,  1, 0, 0,  8'd0,   8'd9,   0,  0,  5,  1};
    tbl[5] = '{8'd128, 8'd128, 16, 0, 0, 8'd1,   8'd0,   0,  0,  20, 1};
    tbl[6] = '{8'd255, 8'd1,   5, 1, 0,  8'd255, 8'd0,   0,  0,  9,  1};
    tbl[7] = '{8'd0,   8'd5,   2, 0, 10, 8'd0,   8'd0,   0,  0,  6,  1};
    tbl[8] = '{8'd250, 8'd0,   4, 0, 3,  8'd255, 8'd250, 1,  0,  1,  0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {3'd0, req_ready, rsp_valid, div_begin, div_inbus,
                            quotient, remainder, err_dbz, err_tmo}, {3'd0, RESET_OUTS});
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send_req(tbl[i]);
      wait_rsp(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while the divider is busy: everything returns to reset values.
    v = '{8'd60, 8'd7, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 1};
    m_delay = 0; m_spur = 0;
    req_valid = 1'b1; dividend = v.a; divisor = v.b;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_state_wait_end", {29'd0, dbg_state}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", {3'd0, req_ready, rsp_valid, div_begin, div_inbus,
                                quotient, remainder, err_dbz, err_tmo}, {3'd0, RESET_OUTS});
    rst = 1'b0;
    @(negedge clk);
    v = '{8'd255, 8'd15, 8, 0, 0, 8'd17, 8'd0, 0, 0, 12, 1};
    send_req(v);
    wait_rsp(v, "post_reset");

    // Random divides with random divider latency and response backpressure.
    for (int i = 0; i < 6; i++) begin
      v.a    = 8'($urandom_range(0, 255));
      v.b    = 8'($urandom_range(1, 255));
      v.d    = $urandom_range(1, 12);
      v.spur = 0;
      v.hold = $urandom_range(0, 3);
      v.q    = v.a / v.b;
      v.r    = v.a % v.b;
      v.dbz  = 0;
      v.tmo  = 0;
      v.lat  = v.d + 4;
      v.nbeg = 1;
      send_req(v);
      wait_rsp(v, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
